// File: rtl/exmem_arbiter.sv
// Two-port arbiter/sequencer in front of the negedge-clocked exmem: one access per cycle, ordered read returns.
// Build option: define EXMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins ties) instead of round-robin.
module exmem_arbiter #(
  parameter int WIDTH         = 8,
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [RAM_ADDR_BITS-1:0] p0_adr,
  input  logic [WIDTH-1:0]         p0_wdata,
  output logic                     p0_gnt,
  output logic                     p0_rvalid,
  output logic [WIDTH-1:0]         p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [RAM_ADDR_BITS-1:0] p1_adr,
  input  logic [WIDTH-1:0]         p1_wdata,
  output logic                     p1_gnt,
  output logic                     p1_rvalid,
  output logic [WIDTH-1:0]         p1_rdata,
  output logic                     mem_en,
  output logic                     mem_memwrite,
  output logic [RAM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]         mem_writedata,
  input  logic [WIDTH-1:0]         mem_memdata
);

  logic w_gnt0, w_gnt1, w_acc0, w_acc1, w_acc;

`ifdef EXMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt0 = reset_n & p0_req;
    w_gnt1 = reset_n & p1_req & ~p0_req;
  end
`else
  // r_rr_p1 = 1 means port 1 wins the next tie.
  logic r_rr_p1;

  always_comb begin
    w_gnt0 = reset_n & p0_req & (~p1_req | ~r_rr_p1);
    w_gnt1 = reset_n & p1_req & (~p0_req |  r_rr_p1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_rr_p1 <= 1'b0;
    else if (w_acc0) r_rr_p1 <= 1'b1;
    else if (w_acc1) r_rr_p1 <= 1'b0;
  end
`endif

  assign p0_gnt = w_gnt0;
  assign p1_gnt = w_gnt1;
  assign w_acc0 = p0_req & w_gnt0;
  assign w_acc1 = p1_req & w_gnt1;
  assign w_acc  = w_acc0 | w_acc1;

  // Stage A: drive exmem for the negedge that follows, and remember who asked.
  logic r_a_rd, r_a_own;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_en        <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      r_a_rd        <= 1'b0;
      r_a_own       <= 1'b0;
    end else if (w_acc) begin
      mem_en        <= 1'b1;
      mem_memwrite  <= w_acc1 ? p1_we    : p0_we;
      mem_adr       <= w_acc1 ? p1_adr   : p0_adr;
      mem_writedata <= w_acc1 ? p1_wdata : p0_wdata;
      r_a_rd        <= w_acc1 ? ~p1_we   : ~p0_we;
      r_a_own       <= w_acc1;
    end else begin
      mem_en        <= 1'b0;
      mem_memwrite  <= 1'b0;
      r_a_rd        <= 1'b0;
    end
  end

  // Stage B: memdata is sampled one edge after issue because a back-to-back
  // access overwrites it on the following negedge.
  logic             r_b_rd, r_b_own;
  logic [WIDTH-1:0] r_b_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b_rd   <= 1'b0;
      r_b_own  <= 1'b0;
      r_b_data <= '0;
    end else begin
      r_b_rd   <= r_a_rd;
      r_b_own  <= r_a_own;
      r_b_data <= mem_memdata;
    end
  end

  logic w_ret0, w_ret1;
  assign w_ret0 = r_b_rd & ~r_b_own;
  assign w_ret1 = r_b_rd &  r_b_own;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= w_ret0;
      p1_rvalid <= w_ret1;
      if (w_ret0) p0_rdata <= r_b_data;
      if (w_ret1) p1_rdata <= r_b_data;
    end
  end

endmodule

// File: tb/tb_exmem_arbiter.sv
// Bench for exmem_arbiter: behavioural exmem, reference RAM and an ordered read-response scoreboard.
module tb_exmem_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       p0_req, p0_we, p1_req, p1_we;
  logic [7:0] p0_adr, p0_wdata, p1_adr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       mem_en, mem_memwrite;
  logic [7:0] mem_adr, mem_writedata, mem_memdata;

  exmem_arbiter #(.WIDTH(8), .RAM_ADDR_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_adr(p0_adr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_adr(p1_adr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_memwrite(mem_memwrite), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
  );

  always #5 clk = ~clk;

  // exmem model: registered read, write on negedge when enabled.
  logic [7:0] ram [256];
  logic [7:0] ref_ram [256];
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_memwrite) ram[mem_adr] <= mem_writedata;
      else              mem_memdata  <= ram[mem_adr];
    end
  end

  typedef struct { bit port; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ret(input bit port, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_rvalid: got port %0d data %0h want none at %0t", port, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("rvalid_port", {31'd0, port}, {31'd0, e.port});
      chk("rdata", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  // Monitor: pop responses, then record accepts (inputs are stable from here to the next posedge).
  always @(negedge clk) begin
    if (p0_gnt && p1_gnt) chk("both_gnt", 1, 0);
    if (p0_rvalid) ret(1'b0, p0_rdata);
    if (p1_rvalid) ret(1'b1, p1_rdata);
    if (reset_n) begin
      if (p0_req && p0_gnt) begin
        if (p0_we) ref_ram[p0_adr] = p0_wdata;
        else       exp_q.push_back('{1'b0, ref_ram[p0_adr]});
      end else if (p1_req && p1_gnt) begin
        if (p1_we) ref_ram[p1_adr] = p1_wdata;
        else       exp_q.push_back('{1'b1, ref_ram[p1_adr]});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [7:0] adr, input logic [7:0] wd);
    p0_req = req; p0_we = we; p0_adr = adr; p0_wdata = wd;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [7:0] adr, input logic [7:0] wd);
    p1_req = req; p1_we = we; p1_adr = adr; p1_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i) ^ 8'h5A;
      ref_ram[i] = 8'(i) ^ 8'h5A;
    end
    ram[8'h20] = 8'h3C; ref_ram[8'h20] = 8'h3C;
    mem_memdata = 8'h00;
    reset_n = 1'b0;
    drv0(1, 0, 8'h00, 8'h00);
    drv1(0, 0, 8'h00, 8'h00);

    // Reset state with a live request
    #12;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_memwrite", mem_memwrite, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
    #5 reset_n = 1'b1;
    @(negedge clk); #1;
    chk("first_p0_gnt", p0_gnt, 1);
    step();
    chk("rd0_mem_en", mem_en, 1);
    chk("rd0_memwrite", mem_memwrite, 0);
    chk("rd0_mem_adr", mem_adr, 8'h00);

    // p1 writes A5 to 0x10, then p0 reads it back on the next cycle
    drv0(0, 0, 8'h00, 8'h00);
    drv1(1, 1, 8'h10, 8'hA5);
    step();
    chk("wr_mem_en", mem_en, 1);
    chk("wr_memwrite", mem_memwrite, 1);
    chk("wr_mem_adr", mem_adr, 8'h10);
    chk("wr_writedata", mem_writedata, 8'hA5);
    drv1(0, 0, 8'h00, 8'h00);
    drv0(1, 0, 8'h10, 8'h00);
    step();
    // read 0x20, write 0x77 to 0x20, read 0x20
    drv0(1, 0, 8'h20, 8'h00);
    step();
    chk("raw_rd_memwrite", mem_memwrite, 0);
    drv0(1, 1, 8'h20, 8'h77);
    step();
    drv0(1, 0, 8'h20, 8'h00);
    step();
    drv0(0, 0, 8'h00, 8'h00);
    step();
    chk("idle_mem_en", mem_en, 0);
    chk("idle_memwrite", mem_memwrite, 0);
    chk("idle_adr_hold", mem_adr, 8'h20);
    repeat (4) step();

    // Reset mid-flight: a read then a write in flight, reset kills both
    drv0(1, 0, 8'h30, 8'h00);
    step();
    drv0(0, 0, 8'h00, 8'h00);
    drv1(1, 1, 8'h30, 8'hEE);
    step();
    chk("pre_rst_mem_en", mem_en, 1);
    #1 reset_n = 1'b0;
    exp_q.delete();
    ref_ram[8'h30] = 8'h30 ^ 8'h5A;
    drv1(0, 0, 8'h00, 8'h00);
    #1;
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_memwrite", mem_memwrite, 0);
    chk("midrst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    step(); #1 reset_n = 1'b1;
    repeat (5) step();

    // Both ports read continuously
    drv0(1, 0, 8'h00, 8'h00);
    drv1(1, 0, 8'h01, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
`ifdef EXMEM_ARB_FIXED_PRIO_EN
      chk("fix_p0_gnt", p0_gnt, 1);
      chk("fix_p1_gnt", p1_gnt, 0);
`else
      chk("rr_p0_gnt", p0_gnt, (i % 2 == 0) ? 1 : 0);
      chk("rr_p1_gnt", p1_gnt, (i % 2 == 0) ? 0 : 1);
`endif
    end
    step();
    drv0(0, 0, 8'h00, 8'h00);
    drv1(0, 0, 8'h00, 8'h00);
    repeat (4) step();

    // The write killed by reset must not have landed
    drv1(1, 0, 8'h30, 8'h00);
    step();
    drv1(0, 0, 8'h00, 8'h00);
    repeat (5) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
